// File: rtl/calc_pkg.sv
// Shared calculator constants: button event codes and clock-derived timing defaults.
package calc_pkg;

   localparam int unsigned EVT_LATCH = 0;
   localparam int unsigned EVT_DUP   = 1;
   localparam int unsigned EVT_PLUS  = 2;
   localparam int unsigned EVT_RESET = 3;

   localparam int unsigned N_BTN_DEF         = 4;
   localparam int unsigned CLK_HZ            = 12_000_000;
   localparam int unsigned DEBOUNCE_DEF      = CLK_HZ / 50;   // 20 ms
   localparam int unsigned REPEAT_DELAY_DEF  = CLK_HZ / 2;    // 0.5 s
   localparam int unsigned REPEAT_PERIOD_DEF = CLK_HZ / 10;   // 0.1 s

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, polarity fix, debounce, press pulse.
// With BTN_EVT_AUTOREPEAT_EN defined it also produces hold-repeat pulses.
module btn_debounce_ch
   import calc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
`ifdef BTN_EVT_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
`ifdef BTN_EVT_AUTOREPEAT_EN
   ,
   output logic rpt
`endif
);

   localparam int unsigned DW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic        RELEASED = BTN_ACTIVE_LOW;

   logic          sync1;
   logic          sync2;
   logic [DW-1:0] cnt;
   logic          sync_c;
   logic          changing_c;

   assign sync_c     = BTN_ACTIVE_LOW ? ~sync2 : sync2;
   assign changing_c = sync1 != sync2;

   // Level only flips after the synchronised value held steady for DEBOUNCE_CYCLES.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RELEASED;
         sync2 <= RELEASED;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync_c == level || changing_c) begin
            cnt <= '0;
         end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            level <= ~level;
            press <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end

`ifdef BTN_EVT_AUTOREPEAT_EN
   localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HW   = cnt_width(HMAX);

   logic [HW-1:0] hcnt;
   logic          repeating;
   logic          hit_c;

   assign hit_c = hcnt == (repeating ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1));

   // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt      <= '0;
         repeating <= 1'b0;
         rpt       <= 1'b0;
      end else if (!level) begin
         hcnt      <= '0;
         repeating <= 1'b0;
         rpt       <= 1'b0;
      end else begin
         rpt <= hit_c;
         if (hit_c) begin
            hcnt      <= '0;
            repeating <= 1'b1;
         end else begin
            hcnt <= hcnt + HW'(1);
         end
      end
   end
`endif

endmodule

// File: rtl/btn_event_gen.sv
// Button front end: debounced channels, per-button pending events, fixed-priority
// valid/ready delivery. Optional hold auto-repeat via BTN_EVT_AUTOREPEAT_EN.
module btn_event_gen
   import calc_pkg::*;
#(
   parameter int unsigned N_BTN           = N_BTN_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1,
`ifdef BTN_EVT_AUTOREPEAT_EN
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
`endif
   localparam int unsigned CW             = cnt_width(N_BTN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic             evt_valid,
   output logic [CW-1:0]    evt_code,
   input  logic             evt_ready,
   output logic             evt_ovf
);

   logic [N_BTN-1:0] press_vec;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] acc_mask_c;
   logic [N_BTN-1:0] remain_c;
   logic [N_BTN-1:0] pending_n_c;
   logic [CW-1:0]    pick_c;
   logic             accept_c;
   logic             ovf_hit_c;
`ifdef BTN_EVT_AUTOREPEAT_EN
   logic [N_BTN-1:0] rpt_vec;
`endif

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
`ifdef BTN_EVT_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[g]),
         .level (btn_level[g]),
         .press (press_vec[g])
`ifdef BTN_EVT_AUTOREPEAT_EN
         ,
         .rpt   (rpt_vec[g])
`endif
      );
   end

   assign accept_c = evt_valid & evt_ready;

   // Remaining pending set after this cycle's accept; lowest index wins the next slot.
   always_comb begin
      acc_mask_c = '0;
      pick_c     = '0;
      if (accept_c) acc_mask_c[evt_code] = 1'b1;
      remain_c   = pending & ~acc_mask_c;
      for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
         if (remain_c[i]) pick_c = CW'(i);
      end
      ovf_hit_c   = |(press_vec & remain_c);
      pending_n_c = remain_c | press_vec;
`ifdef BTN_EVT_AUTOREPEAT_EN
      pending_n_c = pending_n_c | rpt_vec;
`endif
   end

   // Presented code is held until accepted; a new pick happens only when idle or accepting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         evt_valid <= 1'b0;
         evt_code  <= '0;
         evt_ovf   <= 1'b0;
      end else begin
         pending <= pending_n_c;
         if (ovf_hit_c) evt_ovf <= 1'b1;
         if (!evt_valid || evt_ready) begin
            evt_valid <= |remain_c;
            evt_code  <= pick_c;
         end
      end
   end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with short debounce/repeat timings.
module tb_btn_event_gen;
   import calc_pkg::*;

   localparam int unsigned NB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic          evt_valid;
   logic [1:0]    evt_code;
   logic          evt_ready;
   logic          evt_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   btn_event_gen #(
      .N_BTN           (NB),
      .DEBOUNCE_CYCLES (4),
      .BTN_ACTIVE_LOW  (1'b1)
`ifdef BTN_EVT_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ready (evt_ready),
      .evt_ovf   (evt_ovf)
   );

   typedef struct {
      logic [NB-1:0] raw;
      logic          ready;
      logic [NB-1:0] level;
      logic          valid;
      logic [1:0]    code;
   } vec_t;

   vec_t vt [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input int max_cycles, input string name);
      int n;
      n = 0;
      while (!evt_valid && n < max_cycles) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, 32'(evt_valid), 32'd1);
   endtask

   task automatic count_events(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (evt_valid && evt_ready) cnt++;
      end
   endtask

   initial begin
      int cnt;
      int t[4];
      int ne;

      // Test 1 table: btn2 pressed 9 cycles then released; hand-timed level and event
      for (int k = 0; k < 17; k++) begin
         vt[k].raw   = (k < 9) ? 4'b1011 : 4'b1111;
         vt[k].ready = 1'b1;
         vt[k].level = (k >= 5 && k <= 13) ? 4'b0100 : 4'b0000;
         vt[k].valid = (k == 7);
         vt[k].code  = (k == 7) ? 2'(EVT_PLUS) : 2'd0;
      end

      rst       = 1'b1;
      btn_raw   = 4'b1111;
      evt_ready = 1'b0;
      ticks(2);
      check("rst_level", 32'(btn_level), 32'd0);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_code",  32'(evt_code),  32'd0);
      check("rst_ovf",   32'(evt_ovf),   32'd0);
      rst       = 1'b0;
      evt_ready = 1'b1;
      ticks(2);

      for (int k = 0; k < 17; k++) begin
         btn_raw   = vt[k].raw;
         evt_ready = vt[k].ready;
         tick();
         check($sformatf("t1_level[%0d]", k), 32'(btn_level), 32'(vt[k].level));
         check($sformatf("t1_valid[%0d]", k), 32'(evt_valid), 32'(vt[k].valid));
         check($sformatf("t1_code[%0d]",  k), 32'(evt_code),  32'(vt[k].code));
      end

      // Test 2: bounce on btn0 shorter than debounce window
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         btn_raw = ((i / 2) % 2 == 0) ? 4'b1110 : 4'b1111;
         tick();
         if (btn_level != 4'b0000 || evt_valid) cnt++;
      end
      ticks(6);
      check("t2_bounce_activity", 32'(cnt), 32'd0);
      check("t2_level", 32'(btn_level), 32'd0);

      // Test 3: buttons 1 and 3 together, consumer stalled then ready
      evt_ready = 1'b0;
      btn_raw   = 4'b0101;
      wait_valid(20, "t3_wait");
      ticks(1);
      check("t3_code_first", 32'(evt_code), 32'(EVT_DUP));
      ticks(3);
      check("t3_valid_held", 32'(evt_valid), 32'd1);
      check("t3_code_held",  32'(evt_code),  32'(EVT_DUP));
      evt_ready = 1'b1;
      tick();
      check("t3_valid_second", 32'(evt_valid), 32'd1);
      check("t3_code_second",  32'(evt_code),  32'(EVT_RESET));
      tick();
      check("t3_idle", 32'(evt_valid), 32'd0);
      btn_raw = 4'b1111;
      ticks(8);

      // Test 3b: presented code stays put when a lower index becomes pending
      evt_ready = 1'b0;
      btn_raw   = 4'b0111;
      ticks(10);
      check("t3b_code3", 32'(evt_code), 32'(EVT_RESET));
      btn_raw = 4'b0101;
      ticks(10);
      check("t3b_code_stable", 32'(evt_code),  32'(EVT_RESET));
      check("t3b_valid_held",  32'(evt_valid), 32'd1);
      evt_ready = 1'b1;
      tick();
      check("t3b_code_next", 32'(evt_code), 32'(EVT_DUP));
      tick();
      check("t3b_idle", 32'(evt_valid), 32'd0);
      btn_raw = 4'b1111;
      ticks(8);
      check("t3b_no_ovf", 32'(evt_ovf), 32'd0);

      // Test 4: second press merges into pending slot and flags overflow
      evt_ready = 1'b0;
      btn_raw   = 4'b1110;
      ticks(10);
      check("t4_valid", 32'(evt_valid), 32'd1);
      check("t4_ovf_before", 32'(evt_ovf), 32'd0);
      btn_raw = 4'b1111;
      ticks(8);
      btn_raw = 4'b1110;
      ticks(10);
      check("t4_ovf", 32'(evt_ovf), 32'd1);
      check("t4_code", 32'(evt_code), 32'(EVT_LATCH));
      evt_ready = 1'b1;
      tick();
      check("t4_single_event", 32'(evt_valid), 32'd0);
      count_events(10, cnt);
      check("t4_no_more", 32'(cnt), 32'd0);
      btn_raw = 4'b1111;
      ticks(8);
      check("t4_ovf_sticky", 32'(evt_ovf), 32'd1);
      rst = 1'b1;
      tick();
      check("t4_ovf_rst", 32'(evt_ovf), 32'd0);
      rst = 1'b0;
      ticks(2);

      // Test 5: reset while an event is presented with more pending
      evt_ready = 1'b0;
      btn_raw   = 4'b0101;
      ticks(10);
      check("t5_valid_pre", 32'(evt_valid), 32'd1);
      rst = 1'b1;
      tick();
      check("t5_level", 32'(btn_level), 32'd0);
      check("t5_valid", 32'(evt_valid), 32'd0);
      check("t5_code",  32'(evt_code),  32'd0);
      check("t5_ovf",   32'(evt_ovf),   32'd0);
      btn_raw = 4'b1111;
      tick();
      rst       = 1'b0;
      evt_ready = 1'b1;
      count_events(15, cnt);
      check("t5_no_events", 32'(cnt), 32'd0);

      // Test 6: hold button 1 and watch for repeats
      for (int i = 0; i < 4; i++) t[i] = -1000;
      ne      = 0;
      btn_raw = 4'b1101;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (evt_valid) begin
            if (ne < 4) t[ne] = c;
            ne++;
         end
      end
      btn_raw = 4'b1111;
      ticks(10);
`ifdef BTN_EVT_AUTOREPEAT_EN
      check("t6_min_events", 32'(ne >= 4), 32'd1);
      check("t6_rep1", 32'(t[1] - t[0]), 32'd10);
      check("t6_rep2", 32'(t[2] - t[0]), 32'd13);
      check("t6_rep3", 32'(t[3] - t[0]), 32'd16);
`else
      check("t6_one_event", 32'(ne), 32'd1);
      check("t6_first_at", 32'(t[0]), 32'd7);
`endif
      check("t6_idle", 32'(evt_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
